// File: rtl/aig_bench_driver.sv
// Exhaustive input sweep harness for small combinational netlists. It compacts
// the netlist outputs into a MISR signature and checks it against an expected value.
module aig_bench_driver #(
  parameter int unsigned      N_IN     = 9,
  parameter int unsigned      N_OUT    = 6,
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter int unsigned      SETTLE   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic [N_OUT-1:0] f,
  output logic [N_IN-1:0]  x,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    settle_cnt;
  logic [SIG_W-1:0] exp_q;
  logic [SIG_W-1:0] sig_next;

  always_comb begin
    sig_next = {signature[SIG_W-2:0], 1'b0}
             ^ (signature[SIG_W-1] ? SIG_POLY : '0)
             ^ SIG_W'(f);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      signature  <= '0;
      settle_cnt <= '0;
      exp_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= DRIVE;
            x          <= '0;
            signature  <= '0;
            exp_q      <= exp_sig;
            pass       <= 1'b0;
            busy       <= 1'b1;
            settle_cnt <= '0;
          end
        end
        DRIVE: begin
          if (settle_cnt == CW'(SETTLE - 1)) state <= SAMPLE;
          else settle_cnt <= settle_cnt + CW'(1);
        end
        SAMPLE: begin
          signature <= sig_next;
          if (x == '1) begin
            state <= DONE;
          end else begin
            x          <= x + N_IN'(1);
            settle_cnt <= '0;
            state      <= DRIVE;
          end
        end
        DONE: begin
          // done/pass become visible in the following IDLE cycle, so a held
          // start is accepted one cycle after the done pulse.
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (signature == exp_q);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aig_bench_driver.sv
// Self-checking bench for aig_bench_driver: table-driven sweeps against a
// polynomial-arithmetic signature model, plus reset, restart and back-to-back sequences.
module tb_aig_bench_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] exp_sig;
  logic [5:0]  f;
  logic [8:0]  x;
  logic        busy, done, pass;
  logic [15:0] signature;

  logic [5:0]  f_tab [512];
  logic [5:0]  rnd   [512];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign f = f_tab[x];

  aig_bench_driver #(
    .N_IN(9), .N_OUT(6), .SIG_W(16), .SIG_POLY(16'h1021), .SETTLE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_sig(exp_sig), .f(f),
    .x(x), .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  typedef struct {
    int          mode;
    logic [15:0] exp_in;
    logic [15:0] exp_sigv;
    logic        exp_pass;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] fmode(input int mode, input int xv);
    case (mode)
      0:       return 6'd0;
      1:       return (xv == 511) ? 6'd1 : 6'd0;
      2:       return (xv >= 510) ? 6'd1 : 6'd0;
      3:       return 6'(xv % 64);
      default: return rnd[xv];
    endcase
  endfunction

  // Signature as polynomial arithmetic: multiply by the shift variable, reduce
  // modulo x^16 + poly, then add the new output word.
  function automatic logic [15:0] model(input int mode);
    int s = 0;
    for (int i = 0; i < 512; i++) begin
      s = s * 2;
      if (s >= 32'h10000) s = s ^ 32'h11021;
      s = s ^ int'(fmode(mode, i));
    end
    return 16'(s);
  endfunction

  task automatic load_mode(input int mode);
    for (int i = 0; i < 512; i++) f_tab[i] = fmode(mode, i);
  endtask

  // Accepts a start at the next edge, then counts edges until done or the bound.
  task automatic run_sweep(input logic [15:0] e, input int repulse, output int n);
    @(negedge clk);
    exp_sig = e;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_x", x, 0);
    chk("accept_sig", signature, 0);
    n = 0;
    while (n < 4000) begin
      start = (repulse != 0 && n == repulse);
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    start = 1'b0;
    if (!done) chk("sweep_timeout", 0, 1);
  endtask

  initial begin
    int n, dcnt;
    logic [15:0] m3, m4, r;

    rst_n = 1'b0; start = 1'b0; exp_sig = '0;
    for (int i = 0; i < 512; i++) begin
      rnd[i]   = 6'($urandom);
      f_tab[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", signature, 0);
    rst_n = 1'b1;

    m3 = model(3);
    m4 = model(4);
    r  = 16'($urandom);
    tbl[0] = '{0, 16'h0000, 16'h0000, 1'b1};
    tbl[1] = '{1, 16'h0001, 16'h0001, 1'b1};
    tbl[2] = '{1, 16'h0002, 16'h0001, 1'b0};
    tbl[3] = '{2, 16'h0003, 16'h0003, 1'b1};
    tbl[4] = '{3, m3, m3, 1'b1};
    tbl[5] = '{3, m3 ^ 16'h0001, m3, 1'b0};
    tbl[6] = '{4, m4, m4, 1'b1};
    tbl[7] = '{4, r, m4, (r == m4)};

    for (int t = 0; t < 8; t++) begin
      load_mode(tbl[t].mode);
      run_sweep(tbl[t].exp_in, 0, n);
      chk($sformatf("len_%0d", t), n, 1537);
      chk($sformatf("sig_%0d", t), signature, tbl[t].exp_sigv);
      chk($sformatf("pass_%0d", t), pass, tbl[t].exp_pass);
      chk($sformatf("busy_done_%0d", t), busy, 0);
      chk($sformatf("x_last_%0d", t), x, 9'h1FF);
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("frozen_sig_%0d", t), signature, tbl[t].exp_sigv);
      chk($sformatf("frozen_pass_%0d", t), pass, tbl[t].exp_pass);
      chk($sformatf("done_pulse_%0d", t), done, 0);
    end

    // Reset mid-sweep at x == 0x0A5.
    load_mode(3);
    @(negedge clk);
    exp_sig = m3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (x != 9'h0A5 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_0a5", x, 9'h0A5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_x", x, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sig", signature, 0);
    chk("midrst_pass", pass, 0);
    dcnt = 0;
    repeat (2000) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("midrst_no_done", dcnt, 0);

    // Second start pulse during the sweep is ignored.
    load_mode(2);
    run_sweep(16'h0003, 700, n);
    chk("repulse_len", n, 1537);
    chk("repulse_sig", signature, 16'h0003);
    chk("repulse_pass", pass, 1);
    dcnt = 0;
    repeat (1700) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("repulse_single_done", dcnt, 0);
    chk("repulse_idle", busy, 0);

    // Start held high: back-to-back sweeps separated by one IDLE cycle.
    load_mode(1);
    @(negedge clk);
    exp_sig = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    chk("b2b_len1", n, 1537);
    chk("b2b_pass1", pass, 1);
    chk("b2b_idle_gap", busy, 0);
    @(posedge clk); #1;
    chk("b2b_restart_busy", busy, 1);
    chk("b2b_restart_sig", signature, 0);
    start = 1'b0;
    n = 0;
    while (n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    chk("b2b_len2", n, 1537);
    chk("b2b_sig2", signature, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
